// File: rtl/data_reader_if.sv
// data_reader_if: producer/consumer bundle for the data_reader FIFO.
// Master = the surrounding logic (producer + consumer), slave = the FIFO.
interface data_reader_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             rd_en;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             clr_overflow;

    modport master (
        output in_valid, in_data, rd_en, clr_overflow,
        input  in_ready, rd_valid, rd_data, count, overflow
    );

    modport slave (
        input  in_valid, in_data, rd_en, clr_overflow,
        output in_ready, rd_valid, rd_data, count, overflow
    );
endinterface

// File: rtl/data_reader.sv
// data_reader: receive-side first-word-fall-through FIFO with sticky overflow.
// Optional statistics counters (byte_count, drop_count) are built only when
// the macro DATA_READER_STATS_EN is defined.
module data_reader #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    data_reader_if.slave   bus
`ifdef DATA_READER_STATS_EN
    ,
    output logic [15:0]    byte_count,
    output logic [7:0]     drop_count
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic w_in_ready;
    logic w_rd_valid;
    logic w_push;
    logic w_pop;
    logic w_drop;

    // Handshake flags come from the registered occupancy only, so there is
    // no combinational path from in_valid/rd_en to in_ready/rd_valid.
    assign w_in_ready = (r_count != CW'(DEPTH));
    assign w_rd_valid = (r_count != '0);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = bus.rd_en && w_rd_valid;
    assign w_drop     = bus.in_valid && !w_in_ready;

    assign bus.in_ready = w_in_ready;
    assign bus.rd_valid = w_rd_valid;
    assign bus.rd_data  = r_mem[r_rp];
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;

    // Storage write; contents are never reset, stale entries are masked by count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= bus.in_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef DATA_READER_STATS_EN
    logic [15:0] r_byte_count;
    logic [7:0]  r_drop_count;

    // Accepted writes wrap; dropped writes saturate at 0xFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_count <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push) begin
                r_byte_count <= r_byte_count + 16'd1;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign byte_count = r_byte_count;
    assign drop_count = r_drop_count;
`endif

endmodule
